// File: rtl/stack_seq_if.sv
// Request/stack-control bundle between the sequencer and its surroundings.
// The slave side is the sequencer; the master side drives requests and the stack.
interface stack_seq_if #(
    parameter int unsigned DW = 4
);
    localparam int unsigned LW = 5;

    logic          call_req;
    logic          data_req;
    logic          ret_req;
    logic [DW-1:0] pc_in;
    logic [DW-1:0] data_in;
    logic          err_clr;
    logic          full_i;
    logic          empty_i;
    logic [DW-1:0] stack_data_i;

    logic          stack_push;
    logic          stack_pop;
    logic          stack_we;
    logic          stack_re;
    logic          stack_mux_sel;
    logic [DW-1:0] stack_wdata;
    logic          req_ack;
    logic          busy;
    logic          ret_valid;
    logic          err_ovf;
    logic          err_unf;
    logic [DW-1:0] ret_data_o;
    logic [LW-1:0] level_o;

    modport slave (
        input  call_req, data_req, ret_req, pc_in, data_in, err_clr,
               full_i, empty_i, stack_data_i,
        output stack_push, stack_pop, stack_we, stack_re, stack_mux_sel,
               stack_wdata, req_ack, busy, ret_valid, err_ovf, err_unf,
               ret_data_o, level_o
    );

    modport master (
        output call_req, data_req, ret_req, pc_in, data_in, err_clr,
               full_i, empty_i, stack_data_i,
        input  stack_push, stack_pop, stack_we, stack_re, stack_mux_sel,
               stack_wdata, req_ack, busy, ret_valid, err_ovf, err_unf,
               ret_data_o, level_o
    );
endinterface

// File: rtl/stack_seq.sv
// Call/return stack sequencer: arbitrates push/pop requests, drives the stack
// controls one operation at a time and keeps a shadow occupancy count.
module stack_seq #(
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    stack_seq_if.slave  bus
);
    localparam int unsigned LW = 5;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        READ = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          push_q, push_d;
    logic          pop_q, pop_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic          mux_q, mux_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          rvalid_q, rvalid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [LW-1:0] level_q, level_d;
    logic          new_ovf, new_unf;

    // Controls are decoded from the next state so they are registered and
    // line up exactly with the cycle spent in PUSH/POP/READ.
    always_comb begin
        state_d  = state_q;
        push_d   = 1'b0;
        pop_d    = 1'b0;
        we_d     = 1'b0;
        re_d     = 1'b0;
        mux_d    = 1'b0;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        level_d  = level_q;
        new_ovf  = 1'b0;
        new_unf  = 1'b0;

        case (state_q)
            IDLE: begin
                ack_d = bus.call_req | bus.data_req | bus.ret_req;
                if (bus.ret_req) begin
                    if (bus.empty_i || (level_q == '0)) begin
                        new_unf = 1'b1;
                    end else begin
                        state_d = POP;
                        pop_d   = 1'b1;
                    end
                end else if (bus.call_req || bus.data_req) begin
                    if (bus.full_i || (level_q == FULL_LVL)) begin
                        new_ovf = 1'b1;
                    end else begin
                        state_d = PUSH;
                        we_d    = 1'b1;
                        push_d  = 1'b1;
                        mux_d   = ~bus.call_req;
                        wdata_d = bus.call_req ? bus.pc_in : bus.data_in;
                    end
                end
            end
            PUSH: begin
                state_d = IDLE;
                level_d = (level_q == FULL_LVL) ? level_q : level_q + LW'(1);
            end
            POP: begin
                state_d = READ;
                re_d    = 1'b1;
                level_d = (level_q == '0) ? level_q : level_q - LW'(1);
            end
            READ: begin
                state_d  = IDLE;
                rdata_d  = bus.stack_data_i;
                rvalid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        // A fresh error wins over a simultaneous clear.
        ovf_d  = new_ovf | (ovf_q & ~bus.err_clr);
        unf_d  = new_unf | (unf_q & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            mux_q    <= 1'b0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            push_q   <= push_d;
            pop_q    <= pop_d;
            we_q     <= we_d;
            re_q     <= re_d;
            mux_q    <= mux_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
            level_q  <= level_d;
        end
    end

    assign bus.stack_push    = push_q;
    assign bus.stack_pop     = pop_q;
    assign bus.stack_we      = we_q;
    assign bus.stack_re      = re_q;
    assign bus.stack_mux_sel = mux_q;
    assign bus.stack_wdata   = wdata_q;
    assign bus.req_ack       = ack_q;
    assign bus.busy          = busy_q;
    assign bus.ret_valid     = rvalid_q;
    assign bus.err_ovf       = ovf_q;
    assign bus.err_unf       = unf_q;
    assign bus.ret_data_o    = rdata_q;
    assign bus.level_o       = level_q;
endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: a pointer-based stack memory around the DUT and a
// queue-based LIFO model that predicts every handshake, flag and popped value.
module tb_stack_seq;
    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_seq_if #(.DW(DW)) bus ();

    stack_seq #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stack memory: pop moves the pointer down so READ sees the popped entry.
    logic [DW-1:0] env_mem [DEPTH];
    logic [4:0]    env_sp;

    always @(posedge clk) begin
        if (rst) begin
            env_sp <= '0;
        end else if (bus.stack_push && bus.stack_we) begin
            env_mem[env_sp[3:0]] <= bus.stack_wdata;
            env_sp               <= env_sp + 5'd1;
        end else if (bus.stack_pop) begin
            env_sp <= env_sp - 5'd1;
        end
    end

    assign bus.stack_data_i = env_mem[env_sp[3:0]];
    assign bus.full_i       = (env_sp == 5'(DEPTH));
    assign bus.empty_i      = (env_sp == 5'd0);

    logic [DW-1:0] m_stack[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_rdata;
    int            n_cmp;
    int            n_err;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.call_req = 1'b0;
        bus.data_req = 1'b0;
        bus.ret_req  = 1'b0;
        bus.err_clr  = 1'b0;
        bus.pc_in    = '0;
        bus.data_in  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_push"},  8'(bus.stack_push),    8'd0);
        check({tag, "_pop"},   8'(bus.stack_pop),     8'd0);
        check({tag, "_we"},    8'(bus.stack_we),      8'd0);
        check({tag, "_re"},    8'(bus.stack_re),      8'd0);
        check({tag, "_mux"},   8'(bus.stack_mux_sel), 8'd0);
        check({tag, "_ack"},   8'(bus.req_ack),       8'd0);
        check({tag, "_busy"},  8'(bus.busy),          8'd0);
        check({tag, "_rval"},  8'(bus.ret_valid),     8'd0);
        check({tag, "_ovf"},   8'(bus.err_ovf),       8'd0);
        check({tag, "_unf"},   8'(bus.err_unf),       8'd0);
        check({tag, "_rdata"}, 8'(bus.ret_data_o),    8'd0);
        check({tag, "_level"}, 8'(bus.level_o),       8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_stack.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
        check_all_zero("reset");
    endtask

    // One request cycle from IDLE, followed through to the next IDLE cycle.
    task automatic op(input logic c, input logic d, input logic r, input logic clr,
                      input logic [DW-1:0] pc, input logic [DW-1:0] din);
        logic          do_push, do_pop, e_ovf, e_unf, ms;
        logic [DW-1:0] pv;
        do_push = 1'b0;
        do_pop  = 1'b0;
        e_ovf   = 1'b0;
        e_unf   = 1'b0;
        ms      = 1'b0;
        pv      = '0;
        if (r) begin
            if (m_stack.size() == 0) e_unf = 1'b1;
            else                     do_pop = 1'b1;
        end else if (c || d) begin
            if (m_stack.size() == DEPTH) begin
                e_ovf = 1'b1;
            end else begin
                do_push = 1'b1;
                pv      = c ? pc : din;
                ms      = ~c;
            end
        end
        m_ovf = e_ovf | (m_ovf & ~clr);
        m_unf = e_unf | (m_unf & ~clr);

        bus.call_req = c;
        bus.data_req = d;
        bus.ret_req  = r;
        bus.err_clr  = clr;
        bus.pc_in    = pc;
        bus.data_in  = din;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();

        check("ack",   8'(bus.req_ack),       8'(c | d | r));
        check("busy",  8'(bus.busy),          8'(do_push | do_pop));
        check("we",    8'(bus.stack_we),      8'(do_push));
        check("push",  8'(bus.stack_push),    8'(do_push));
        check("mux",   8'(bus.stack_mux_sel), 8'(do_push & ms));
        check("pop",   8'(bus.stack_pop),     8'(do_pop));
        check("re",    8'(bus.stack_re),      8'd0);
        check("rval0", 8'(bus.ret_valid),     8'd0);
        check("ovf",   8'(bus.err_ovf),       8'(m_ovf));
        check("unf",   8'(bus.err_unf),       8'(m_unf));

        if (do_push) begin
            check("wdata", 8'(bus.stack_wdata), 8'(pv));
            m_stack.push_back(pv);
            @(negedge clk);
            check("push_busy", 8'(bus.busy),     8'd0);
            check("push_we",   8'(bus.stack_we), 8'd0);
            check("push_ack",  8'(bus.req_ack),  8'd0);
        end
        if (do_pop) begin
            m_rdata = m_stack.pop_back();
            @(negedge clk);
            check("read_re",   8'(bus.stack_re),  8'd1);
            check("read_pop",  8'(bus.stack_pop), 8'd0);
            check("read_busy", 8'(bus.busy),      8'd1);
            check("read_rval", 8'(bus.ret_valid), 8'd0);
            @(negedge clk);
            check("rval",      8'(bus.ret_valid), 8'd1);
            check("rval_busy", 8'(bus.busy),      8'd0);
            check("rval_re",   8'(bus.stack_re),  8'd0);
        end
        check("level", 8'(bus.level_o),    8'(m_stack.size()));
        check("rdata", 8'(bus.ret_data_o), 8'(m_rdata));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          c, d, r, clr;
        logic [DW-1:0] pc, din;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < int'(DEPTH); i++) env_mem[i] = '0;
        do_reset();

        // Underflow straight out of reset, then clear.
        op(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        op(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);

        // Call then data push, popped back in LIFO order.
        op(1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0);
        op(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h3);
        op(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        op(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);

        // ret beats call in the same cycle; call is not queued.
        op(1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 4'h0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 4'h0);
        // call beats data.
        op(1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'hC);
        op(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);

        // Fill, overflow, clear racing a new overflow, then clear.
        for (int i = 0; i < int'(DEPTH); i++)
            op(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'h0);
        op(1'b1, 1'b0, 1'b0, 1'b0, 4'hE, 4'h0);
        op(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h1);
        op(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        for (int i = 0; i < int'(DEPTH); i++)
            op(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);

        // A held data_req re-triggers each time the sequencer returns to IDLE.
        bus.data_req = 1'b1;
        bus.data_in  = 4'h5;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("hold_we", 8'(bus.stack_we), 8'(i % 2));
        end
        clear_inputs();
        m_stack.push_back(4'h5);
        m_stack.push_back(4'h5);
        check("hold_level", 8'(bus.level_o), 8'd2);
        op(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);

        // Reset during READ aborts the pop.
        bus.ret_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("abort_re", 8'(bus.stack_re), 8'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_stack.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
        check_all_zero("abort");
        @(negedge clk);
        check("abort_rval2", 8'(bus.ret_valid), 8'd0);

        // Random traffic against the LIFO model.
        for (int n = 0; n < 300; n++) begin
            r   = ($urandom_range(0, 9) < 4);
            c   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            pc  = 4'($urandom_range(0, 15));
            din = 4'($urandom_range(0, 15));
            op(c, d, r, clr, pc, din);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have parameter DW, default 4, stack data width.
REQ-002 SHALL have parameter DEPTH, default 16, stack entry count; level width is 5 bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port call_req  input  1  push pc_in as a return address.
REQ-006 SHALL have port data_req  input  1  push data_in as an operand.
REQ-007 SHALL have port ret_req  input  1  pop top entry to ret_data_o.
REQ-008 SHALL have ports pc_in and data_in  input  DW  push sources.
REQ-009 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-010 SHALL have ports full_i and empty_i  input  1  stack status from the stack pointer.
REQ-011 SHALL have port stack_data_i  input  DW  stack read data, combinational on stack_re.
REQ-012 SHALL have ports stack_push, stack_pop, stack_we, stack_re and stack_mux_sel  output  1  stack controls; mux_sel=1 selects data_in, 0 selects pc_in.
REQ-013 SHALL have ports req_ack, busy and ret_valid  output  1  handshake and status.
REQ-014 SHALL have ports err_ovf and err_unf  output  1  sticky overflow and underflow flags.
REQ-015 SHALL have port ret_data_o  output  DW  registered popped value.
REQ-016 SHALL have port level_o  output  5  shadow occupancy, 0..DEPTH.

Function
REQ-017 SHALL implement FSM states IDLE, PUSH, POP and READ.
REQ-018 SHALL sample requests only in IDLE, with priority ret_req > call_req > data_req; lower-priority requests asserted in the same cycle are ignored and not queued.
REQ-019 SHALL pulse req_ack for exactly one cycle, in the cycle after an IDLE cycle with any request asserted, whether or not the request is accepted.
REQ-020 SHALL hold busy=1 in PUSH, POP and READ, and busy=0 in IDLE.
REQ-021 IDLE to PUSH on an accepted call_req or data_req; in PUSH assert stack_we=1 and stack_push=1 for one cycle, with stack_mux_sel=0 for call and 1 for data.
REQ-022 PUSH SHALL use a latched copy of pc_in or data_in captured at acceptance, then return to IDLE; level_o increments by 1.
REQ-023 IDLE to POP on an accepted ret_req; in POP assert stack_pop=1 for one cycle; level_o decrements by 1.
REQ-024 POP to READ unconditionally; in READ assert stack_re=1 and register stack_data_i into ret_data_o at the end of the cycle, then return to IDLE.
REQ-025 SHALL pulse ret_valid for one cycle in the cycle after READ; ret_data_o holds its value until the next READ.
REQ-026 SHALL detect a push request while full_i=1 or level_o=DEPTH as overflow: set err_ovf, remain in IDLE, and assert no stack controls.
REQ-027 SHALL detect ret_req while empty_i=1 or level_o=0 as underflow: set err_unf, remain in IDLE, assert no stack controls, and leave ret_data_o unchanged.
REQ-028 SHALL clear err_ovf and err_unf when err_clr=1, unless a new error is detected in the same cycle, in which case that error flag stays set.
REQ-029 level_o SHALL saturate at 0 and DEPTH and never wrap.
REQ-030 Outside the states named in REQ-021 to REQ-024, all stack control outputs SHALL be 0, and at most one of stack_we/stack_push and stack_pop/stack_re SHALL be active in any cycle.
REQ-031 Requests held asserted across back-to-back operations SHALL re-trigger each time the FSM returns to IDLE.

Reset
REQ-032 rst=1 SHALL force state IDLE and set every output to 0, including level_o=0, ret_data_o=0 and both error flags, at the next clock edge.
REQ-033 rst asserted mid-operation (PUSH, POP or READ) SHALL abort the operation with no ret_valid and no further stack control pulses; rst has priority over all other inputs.
REQ-034 The team drives the stack pointer reset from the same rst so that level_o and the stack pointer stay aligned.

Verification
REQ-035 call_req with pc_in=4'hA, then data_req with data_in=4'h3 -> two PUSH cycles (mux_sel 0 then 1), and level_o=2.
REQ-036 Following REQ-035, two ret_req operations -> ret_data_o=4'h3 then 4'hA, each ret_valid 3 cycles after the request, and level_o=0.
REQ-037 16 pushes followed by a 17th call_req -> err_ovf=1, no stack_we on the 17th, and level_o=16; err_clr=1 -> err_ovf=0.
REQ-038 ret_req from reset -> err_unf=1, no stack_pop, and ret_data_o=0.
REQ-039 ret_req and call_req asserted in the same cycle with level_o=1 -> POP taken and level_o=0; call not queued.
REQ-040 rst asserted during READ -> next cycle state IDLE, ret_valid=0, level_o=0, and all controls 0.
